interp_frame_player: RTL and testbench

- Playback reader on the output side of the linear-interpolation resampler.
- After the interpolator signals frame complete, the block reads the interpolated frame out of the output RAM read port and presents one sample per DAC sample strobe.
- When a frame is exhausted, it pulses a request so upstream computes the next frame into the same RAM.
- Missing data (underrun) is reported and replaced with silence.

---
 rtl/interp_frame_player.sv | 111 +++++++++++
 tb/tb_interp_frame_player.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/interp_frame_player.sv
// Playback reader for the resampler's output RAM: waits for a finished frame, serves one
// sample per DAC strobe, requests the next frame when exhausted and substitutes silence on underrun.
module interp_frame_player #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] frame_len,
  input  logic                  frame_done,
  output logic                  frame_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  sample_req,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid,
  output logic                  busy,
  output logic [15:0]           underrun_cnt,
  output logic [1:0]            dbg_state
);

  // Strobe protocol: frame_done, frame_req, sample_req and sample_valid are single-cycle
  // pulses with no back-pressure; sample_valid follows its sample_req by exactly one clock.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_PLAY = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH-1:0] r_len;
  logic [DATA_WIDTH-1:0] r_sample_out;
  logic                  r_sample_valid;
  logic                  r_frame_req;
  logic                  r_busy;
  logic [15:0]           r_underrun_cnt;
  logic                  w_serve;
  logic                  w_underrun;
  logic                  w_last;
  logic                  w_load;

  assign w_last     = (r_idx == r_len);
  assign w_serve    = enable && sample_req && (r_state == S_PLAY);
  assign w_underrun = enable && sample_req && ((r_state == S_REQ) || (r_state == S_WAIT));
  assign w_load     = enable && frame_done && (r_state == S_WAIT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_next = S_REQ;
      S_REQ:   w_next = S_WAIT;
      S_WAIT:  if (frame_done) w_next = S_PLAY;
      S_PLAY:  if (sample_req && w_last) w_next = S_REQ;
      default: w_next = S_IDLE;
    endcase
    if (!enable) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // The read address is the play index itself, so RAM data is settled well before the next strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_len <= '0;
    end else if (!enable) begin
      r_idx <= '0;
    end else if (w_load) begin
      r_idx <= '0;
      r_len <= frame_len;
    end else if (w_serve && !w_last) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_out   <= '0;
      r_sample_valid <= 1'b0;
      r_frame_req    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_sample_valid <= w_serve || w_underrun;
      r_frame_req    <= enable && (r_state == S_REQ);
      r_busy         <= enable && (r_state == S_PLAY);
      if (!enable || w_underrun) r_sample_out <= '0;
      else if (w_serve)          r_sample_out <= rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     r_underrun_cnt <= '0;
    else if (w_underrun && r_underrun_cnt != 16'hFFFF) r_underrun_cnt <= r_underrun_cnt + 16'd1;
  end

  assign frame_req    = r_frame_req;
  assign rd_addr      = r_idx;
  assign sample_out   = r_sample_out;
  assign sample_valid = r_sample_valid;
  assign busy         = r_busy;
  assign underrun_cnt = r_underrun_cnt;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_interp_frame_player.sv
// Randomised bench for interp_frame_player against a frame-level playback model
// (frames as queues of samples, underruns as zero samples with a saturating count).
module tb_interp_frame_player;
  localparam int DW = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [AW-1:0] frame_len = '0;
  logic          frame_done = 1'b0;
  logic          sample_req = 1'b0;
  logic          frame_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] sample_out;
  logic          sample_valid;
  logic          busy;
  logic [15:0]   underrun_cnt;
  logic [1:0]    dbg_state;

  interp_frame_player #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_len(frame_len),
    .frame_done(frame_done), .frame_req(frame_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .sample_req(sample_req), .sample_out(sample_out),
    .sample_valid(sample_valid), .busy(busy), .underrun_cnt(underrun_cnt),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) rd_data <= ram[rd_addr];

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];
  int frq_cnt = 0;
  int exp_frq = 0;
  bit frq_prev = 1'b0;

  bit m_en = 1'b0;
  bit m_playing = 1'b0;
  logic [DW-1:0] m_frame[$];
  logic [15:0] m_cnt = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (frame_req) begin
      frq_cnt++;
      check("frq_one_cycle", {31'd0, frq_prev}, 32'd0);
    end
    frq_prev = frame_req;
  end

  task automatic model_sample();
    if (!m_en) return;
    if (m_playing) begin
      exp_q.push_back(m_frame.pop_front());
      if (m_frame.size() == 0) begin
        m_playing = 1'b0;
        exp_frq++;
      end
    end else begin
      exp_q.push_back('0);
      if (m_cnt != 16'hFFFF) m_cnt++;
    end
  endtask

  task automatic model_frame_done(input logic [AW-1:0] len);
    if (m_en && !m_playing) begin
      m_frame.delete();
      for (int i = 0; i <= int'(len); i++) m_frame.push_back(ram[i]);
      m_playing = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit sreq, input bit fdone, input logic [AW-1:0] flen);
    int n0;
    @(negedge clk);
    frame_len  = flen;
    sample_req = sreq;
    frame_done = fdone;
    n0 = exp_q.size();
    if (sreq) model_sample();
    if (fdone) model_frame_done(flen);
    @(negedge clk);
    sample_req = 1'b0;
    frame_done = 1'b0;
    if (exp_q.size() > n0) begin
      check("sample_valid", {31'd0, sample_valid}, 32'd1);
      check("sample_out", {16'd0, sample_out}, {16'd0, exp_q.pop_front()});
    end else if (sreq) begin
      check("no_valid_idle", {31'd0, sample_valid}, 32'd0);
    end
  endtask

  task automatic play_req();
    drive(1'b1, 1'b0, AW'($urandom_range(0, 15)));
    idle($urandom_range(2, 6));
  endtask

  task automatic set_enable(input bit b);
    @(negedge clk);
    enable = b;
    if (b && !m_en) exp_frq++;
    m_en = b;
    if (!b) begin
      m_playing = 1'b0;
      m_frame.delete();
    end
  endtask

  task automatic fill_ram(input int len);
    for (int i = 0; i <= len; i++) ram[i] = DW'($urandom) | 16'h0001;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i * 3);
    idle(3);
    rst_n = 1'b1;
    idle(2);
    check("rst_sample_out", {16'd0, sample_out}, 32'd0);
    check("rst_rd_addr", {22'd0, rd_addr}, 32'd0);
    check("rst_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_frame_req", {31'd0, frame_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_underrun", {16'd0, underrun_cnt}, 32'd0);
    drive(1'b1, 1'b0, '0);

    // frame_req exactly two clocks after enable
    set_enable(1'b1);
    @(negedge clk); check("frq_t1", {31'd0, frame_req}, 32'd0);
    @(negedge clk); check("frq_t2", {31'd0, frame_req}, 32'd1);
    @(negedge clk); check("frq_t3", {31'd0, frame_req}, 32'd0);
    idle(5);
    check("wait_busy", {31'd0, busy}, 32'd0);
    check("wait_underrun", {16'd0, underrun_cnt}, 32'd0);
    check("wait_frq_cnt", frq_cnt, 1);

    // ramp frame 0,3,6,9,12
    drive(1'b0, 1'b1, AW'(4));
    idle(3);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, AW'(9));
      idle(7);
    end
    drive(1'b1, 1'b0, AW'(9));
    check("end_busy_hold", {31'd0, busy}, 32'd1);
    check("end_frq_early", {31'd0, frame_req}, 32'd0);
    @(negedge clk);
    check("end_frq", {31'd0, frame_req}, 32'd1);
    check("end_busy_drop", {31'd0, busy}, 32'd0);
    idle(3);

    // three underruns, then the next frame from address 0
    repeat (3) play_req();
    check("underrun_3", {16'd0, underrun_cnt}, 32'd3);
    drive(1'b0, 1'b1, AW'(4));
    idle(3);
    while (m_playing) play_req();

    // frame_done coincident with sample_req in WAIT
    fill_ram(4);
    drive(1'b1, 1'b1, AW'(4));
    check("coinc_underrun", {16'd0, underrun_cnt}, 32'd4);
    idle(3);
    while (m_playing) play_req();

    // disable mid-frame at idx=2
    fill_ram(7);
    drive(1'b0, 1'b1, AW'(7));
    idle(3);
    play_req();
    play_req();
    set_enable(1'b0);
    @(negedge clk);
    check("dis_state", {30'd0, dbg_state}, 32'd0);
    check("dis_sample_out", {16'd0, sample_out}, 32'd0);
    check("dis_rd_addr", {22'd0, rd_addr}, 32'd0);
    drive(1'b1, 1'b0, '0);
    set_enable(1'b1);
    idle(4);
    check("reen_frq_cnt", frq_cnt, exp_frq);
    drive(1'b0, 1'b1, AW'(7));
    idle(3);
    while (m_playing) play_req();

    // asynchronous reset mid-frame
    fill_ram(7);
    drive(1'b0, 1'b1, AW'(7));
    idle(3);
    play_req();
    play_req();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sample_out", {16'd0, sample_out}, 32'd0);
    check("arst_rd_addr", {22'd0, rd_addr}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_underrun", {16'd0, underrun_cnt}, 32'd0);
    check("arst_state", {30'd0, dbg_state}, 32'd0);
    enable = 1'b0;
    m_en = 1'b0;
    m_playing = 1'b0;
    m_frame.delete();
    m_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // single-sample frame
    set_enable(1'b1);
    idle(4);
    fill_ram(0);
    drive(1'b0, 1'b1, '0);
    idle(3);
    drive(1'b1, 1'b0, AW'(5));
    check("len0_frq_early", {31'd0, frame_req}, 32'd0);
    @(negedge clk);
    check("len0_frq", {31'd0, frame_req}, 32'd1);
    idle(3);

    // saturation of the underrun counter
    force dut.r_underrun_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.r_underrun_cnt;
    m_cnt = 16'hFFFE;
    repeat (3) play_req();
    check("sat_ffff", {16'd0, underrun_cnt}, 32'h0000FFFF);

    // random frames with random underruns, coincident loads and frame_len churn
    for (int f = 0; f < 20; f++) begin
      int len;
      len = $urandom_range(0, 9);
      fill_ram(len);
      repeat ($urandom_range(0, 2)) play_req();
      drive(1'($urandom_range(0, 1)), 1'b1, AW'(len));
      idle($urandom_range(2, 5));
      while (m_playing) play_req();
      check("rnd_underrun", {16'd0, underrun_cnt}, {16'd0, m_cnt});
    end

    idle(4);
    check("final_frq_cnt", frq_cnt, exp_frq);
    check("final_exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
